// File: rtl/vga_frame_scanner.sv
// VGA raster timing generator and frame-buffer read sequencer for an upscaled image window.
// Sync/blank/first-pixel flags are delayed to line up with buffer read data at the DAC pins.
module vga_frame_scanner #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned IMG_W       = 64,
    parameter int unsigned IMG_H       = 64,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic              vgaClk,
    input  logic              reset,
    input  logic [1:0]        pixelIn,
    output logic [ADDR_W-1:0] readAddr,
    output logic              readEn,
    output logic [1:0]        pixelOut,
    output logic              hSync,
    output logic              vSync,
    output logic              syncB,
    output logic              blankB,
    output logic              frameStart
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW         = $clog2(H_TOTAL);
    localparam int unsigned VW         = $clog2(V_TOTAL);
    localparam int unsigned IMG_W_PIX  = IMG_W << SCALE_SHIFT;
    localparam int unsigned IMG_H_PIX  = IMG_H << SCALE_SHIFT;
    localparam int unsigned IMG_W_BITS = $clog2(IMG_W);

    if (IMG_W_PIX > H_ACTIVE || IMG_H_PIX > V_ACTIVE) begin : g_bad_window
        $error("vga_frame_scanner: upscaled image window exceeds active area");
    end
    if (RD_LAT < 1) begin : g_bad_latency
        $error("vga_frame_scanner: RD_LAT must be at least 1");
    end
    if ((64'd1 << ADDR_W) < 64'(IMG_W) * 64'(IMG_H)) begin : g_bad_addr
        $error("vga_frame_scanner: ADDR_W too narrow for IMG_W*IMG_H");
    end

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
        logic in_img;
        logic first;
    } ctl_t;

    localparam ctl_t CtlReset = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, in_img: 1'b0,
                                  first: 1'b0};

    logic [HW-1:0]     h_count_q;
    logic [VW-1:0]     v_count_q;
    ctl_t              s0_ctl;
    logic [ADDR_W-1:0] img_addr;
    ctl_t              s1_q;
    ctl_t              dly_q [RD_LAT];

    always_ff @(posedge vgaClk) begin
        if (reset) begin
            h_count_q <= '0;
            v_count_q <= '0;
        end else if (h_count_q == HW'(H_TOTAL - 1)) begin
            h_count_q <= '0;
            v_count_q <= (v_count_q == VW'(V_TOTAL - 1)) ? '0 : v_count_q + 1'b1;
        end else begin
            h_count_q <= h_count_q + 1'b1;
        end
    end

    always_comb begin
        s0_ctl         = CtlReset;
        s0_ctl.visible = (32'(h_count_q) < H_ACTIVE) && (32'(v_count_q) < V_ACTIVE);
        s0_ctl.in_img  = s0_ctl.visible && (32'(h_count_q) < IMG_W_PIX)
                         && (32'(v_count_q) < IMG_H_PIX);
        s0_ctl.hsync   = !((32'(h_count_q) >= H_ACTIVE + H_FP)
                           && (32'(h_count_q) < H_ACTIVE + H_FP + H_SYNC));
        s0_ctl.vsync   = !((32'(v_count_q) >= V_ACTIVE + V_FP)
                           && (32'(v_count_q) < V_ACTIVE + V_FP + V_SYNC));
        s0_ctl.first   = (h_count_q == '0) && (v_count_q == '0);
        // IMG_W is a power of two, so row*IMG_W + col is a plain bit concatenation
        img_addr       = ADDR_W'(((32'(v_count_q) >> SCALE_SHIFT) << IMG_W_BITS)
                                 | (32'(h_count_q) >> SCALE_SHIFT));
    end

    always_ff @(posedge vgaClk) begin
        if (reset) begin
            s1_q     <= CtlReset;
            readEn   <= 1'b0;
            readAddr <= '0;
            for (int i = 0; i < RD_LAT; i++) dly_q[i] <= CtlReset;
        end else begin
            s1_q   <= s0_ctl;
            readEn <= s0_ctl.in_img;
            if (s0_ctl.in_img) readAddr <= img_addr;
            dly_q[0] <= s1_q;
            for (int i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    // Last delay stage is coincident with the read data for the same pixel
    always_ff @(posedge vgaClk) begin
        if (reset) begin
            pixelOut   <= 2'b00;
            hSync      <= 1'b1;
            vSync      <= 1'b1;
            blankB     <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            pixelOut   <= dly_q[RD_LAT-1].in_img ? pixelIn : 2'b00;
            hSync      <= dly_q[RD_LAT-1].hsync;
            vSync      <= dly_q[RD_LAT-1].vsync;
            blankB     <= dly_q[RD_LAT-1].visible;
            frameStart <= dly_q[RD_LAT-1].first;
        end
    end

    assign syncB = 1'b0;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench for vga_frame_scanner: full horizontal timing, shortened vertical timing so
// whole frames fit in a short run, plus a mid-frame reset.
module tb_vga_frame_scanner;

    localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACTIVE = 20, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int IMG_W = 64, IMG_H = 4, ADDR_W = 8, SCALE_SHIFT = 2, RD_LAT = 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOTAL * V_TOTAL;

    logic              vgaClk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        pixelIn = 2'b00;
    logic [ADDR_W-1:0] readAddr;
    logic              readEn;
    logic [1:0]        pixelOut;
    logic              hSync, vSync, syncB, blankB, frameStart;

    vga_frame_scanner #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .SCALE_SHIFT(SCALE_SHIFT),
        .RD_LAT(RD_LAT)
    ) dut (
        .vgaClk(vgaClk), .reset(reset), .pixelIn(pixelIn), .readAddr(readAddr),
        .readEn(readEn), .pixelOut(pixelOut), .hSync(hSync), .vSync(vSync), .syncB(syncB),
        .blankB(blankB), .frameStart(frameStart)
    );

    always #5 vgaClk = ~vgaClk;

    typedef struct {
        int         x;
        int         y;
        logic [1:0] pix;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
    } pin_exp_t;

    typedef struct {
        int                x;
        int                y;
        logic              en;
        logic [ADDR_W-1:0] addr;
    } rd_exp_t;

    pin_exp_t pin_q[$];
    rd_exp_t  rd_q[$];

    int errors = 0;
    int checks = 0;
    int c = 0;
    logic [ADDR_W-1:0] exp_addr_last;
    logic              prev_en;
    logic [ADDR_W-1:0] prev_addr;
    logic prev_hs, prev_vs, prev_blank;
    int   blank_rise, hs_fall, vs_fall, fs_last, fs_count;
    bit   rise_fresh;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, c);
        end
    endtask

    // Call in the first cycle after the last reset edge; that cycle is counter position (0,0).
    task automatic restart();
        pin_exp_t pr;
        rd_exp_t  rr;
        pin_q.delete();
        rd_q.delete();
        pr = '{x: -1, y: -1, pix: 2'b00, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0};
        rr = '{x: -1, y: -1, en: 1'b0, addr: '0};
        repeat (2 + RD_LAT) pin_q.push_back(pr);
        rd_q.push_back(rr);
        exp_addr_last = '0;
        c = 0;
        prev_en = 1'b0;
        prev_addr = '0;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        prev_blank = 1'b0;
        blank_rise = -1;
        hs_fall = -1;
        vs_fall = -1;
        fs_last = -1;
        fs_count = 0;
        rise_fresh = 1'b0;
    endtask

    task automatic step();
        int x = c % H_TOTAL;
        int y = (c / H_TOTAL) % V_TOTAL;
        bit vis, inimg;
        pin_exp_t pe, po;
        rd_exp_t  re, ro;

        // Buffer model: data for the address presented last cycle; garbage when no read
        pixelIn = prev_en ? prev_addr[1:0] : 2'($urandom);
        prev_en = readEn;
        prev_addr = readAddr;

        vis = (x < H_ACTIVE) && (y < V_ACTIVE);
        inimg = vis && (x < (IMG_W << SCALE_SHIFT)) && (y < (IMG_H << SCALE_SHIFT));
        pe.x = x;
        pe.y = y;
        pe.pix = inimg ? 2'((x >> SCALE_SHIFT) & 3) : 2'b00;
        pe.hs = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
        pe.vs = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
        pe.blank = vis;
        pe.fs = (x == 0) && (y == 0);
        pin_q.push_back(pe);
        if (inimg) exp_addr_last = ADDR_W'((y >> SCALE_SHIFT) * IMG_W + (x >> SCALE_SHIFT));
        re = '{x: x, y: y, en: inimg, addr: exp_addr_last};
        rd_q.push_back(re);

        po = pin_q.pop_front();
        check_eq("pixelOut", pixelOut, po.pix);
        check_eq("hSync", hSync, po.hs);
        check_eq("vSync", vSync, po.vs);
        check_eq("blankB", blankB, po.blank);
        check_eq("frameStart", frameStart, po.fs);
        check_eq("syncB", syncB, 0);
        if (po.x == 5 && po.y == 0) check_eq("pix_x5_line0", pixelOut, 1);

        ro = rd_q.pop_front();
        check_eq("readEn", readEn, ro.en);
        check_eq("readAddr", readAddr, ro.addr);
        if (ro.x == 5 && ro.y == 9) check_eq("addr_x5_y9", readAddr, 129);
        if (ro.x == 255 && ro.y == 15) check_eq("addr_last", readAddr, 255);
        if (ro.x == 256 && ro.y == 0) check_eq("en_x256", readEn, 0);

        if (!prev_blank && blankB) begin
            blank_rise = c;
            rise_fresh = 1'b1;
        end
        if (prev_hs && !hSync) begin
            if (rise_fresh) check_eq("hs_fall_after_blank", c - blank_rise, H_ACTIVE + H_FP);
            if (hs_fall >= 0) check_eq("hs_period", c - hs_fall, H_TOTAL);
            rise_fresh = 1'b0;
            hs_fall = c;
        end
        if (!prev_hs && hSync && hs_fall >= 0) check_eq("hs_width", c - hs_fall, H_SYNC);
        if (prev_vs && !vSync) vs_fall = c;
        if (!prev_vs && vSync && vs_fall >= 0) check_eq("vs_width", c - vs_fall, V_SYNC * H_TOTAL);
        if (frameStart) begin
            if (fs_last >= 0) check_eq("fs_period", c - fs_last, FRAME);
            fs_last = c;
            fs_count++;
        end
        prev_hs = hSync;
        prev_vs = vSync;
        prev_blank = blankB;

        @(posedge vgaClk);
        #1;
        c++;
    endtask

    initial begin
        reset = 1'b1;
        repeat (4) @(posedge vgaClk);
        #1;
        reset = 1'b0;
        restart();

        // One full frame, then on into the next one up to (x=300, y=10)
        repeat (FRAME + 10 * H_TOTAL + 300) step();
        check_eq("fs_count_run1", fs_count, 2);

        reset = 1'b1;
        @(posedge vgaClk);
        #1;
        reset = 1'b0;
        restart();
        repeat (2000) step();
        check_eq("fs_count_run2", fs_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
